// File: rtl/specinvert_pkg.sv
// Shared definitions for the specinvert core: per-channel mode encoding,
// default geometry and the saturating negate helper.
package specinvert_pkg;

  localparam int ITEM_W_DEF = 32;
  localparam int NUM_CH_DEF = 2;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_CONJ   = 2'b01,
    MODE_FS2    = 2'b10,
    MODE_SWAP   = 2'b11
  } specinv_mode_t;

  // Negates the low w bits of x (two's complement). Returns {sat, value}:
  // the most negative input maps to the most positive value and sets sat.
  function automatic logic [32:0] sat_neg(input logic [31:0] x, input int w);
    logic [63:0] mask;
    logic [63:0] xe;
    logic [63:0] mn;
    logic [63:0] neg;
    mask = (64'd1 << w) - 64'd1;
    xe   = {32'd0, x} & mask;
    mn   = 64'd1 << (w - 1);
    neg  = (~xe + 64'd1) & mask;
    if (xe == mn) begin
      sat_neg = {1'b1, 32'(mn - 64'd1)};
    end else begin
      sat_neg = {1'b0, neg[31:0]};
    end
  endfunction

endpackage

// File: rtl/specinvert_mc_core_if.sv
// AXI-Stream style bundle carrying NUM_CH complex items per beat.
// Handshake: a beat transfers on a clock edge where tvalid and tready are
// both high; once tvalid is raised, tdata/tlast stay stable until that
// transfer, and tvalid must not depend on tready.
interface specinvert_mc_core_if #(
  parameter int NUM_CH = 2,
  parameter int ITEM_W = 32
);
  logic [NUM_CH*ITEM_W-1:0] tdata;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/specinvert_lane.sv
// Combinational per-channel arithmetic: bypass, conjugate, fs/2 shift
// (negate both components on odd parity) or I/Q swap. Q is the upper half
// of the item, I the lower half. sat_o flags a saturated negation that was
// actually used for the result.
module specinvert_lane
  import specinvert_pkg::*;
#(
  parameter int ITEM_W = ITEM_W_DEF
) (
  input  logic [ITEM_W-1:0] item_i,
  input  specinv_mode_t     mode_i,
  input  logic              parity_i,
  output logic [ITEM_W-1:0] item_o,
  output logic              sat_o
);
  localparam int HW = ITEM_W / 2;

  logic [HW-1:0] i_c;
  logic [HW-1:0] q_c;
  logic [32:0]   ni_r;
  logic [32:0]   nq_r;
  logic          unused_bits;

  assign i_c  = item_i[HW-1:0];
  assign q_c  = item_i[ITEM_W-1:HW];
  assign ni_r = sat_neg(32'(i_c), HW);
  assign nq_r = sat_neg(32'(q_c), HW);
  assign unused_bits = ^{ni_r, nq_r};

  // Select the result for the applied mode
  always_comb begin
    item_o = item_i;
    sat_o  = 1'b0;
    case (mode_i)
      MODE_BYPASS: item_o = item_i;
      MODE_CONJ: begin
        item_o = {nq_r[HW-1:0], i_c};
        sat_o  = nq_r[32];
      end
      MODE_FS2: begin
        if (parity_i) begin
          item_o = {nq_r[HW-1:0], ni_r[HW-1:0]};
          sat_o  = nq_r[32] | ni_r[32];
        end
      end
      MODE_SWAP: item_o = {i_c, q_c};
      default: item_o = item_i;
    endcase
  end

endmodule

// File: rtl/specinvert_mc_core.sv
// Multi-channel spectral manipulation core. Two-stage pipeline with one
// global enable (en = m ready | ~stage2 valid). Per-channel modes latch
// only on packet-start beats; fs/2 parity is a shared toggle bit.
// Optional statistics counters are built when SPECINV_STATS_EN is defined.
module specinvert_mc_core
  import specinvert_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int ITEM_W         = ITEM_W_DEF,
  parameter int PARITY_PER_PKT = 1
) (
  input  logic                  ce_clk,
  input  logic                  ce_rst_n,
  specinvert_mc_core_if.slave   s_axis,
  specinvert_mc_core_if.master  m_axis,
  input  logic [2*NUM_CH-1:0]   cfg_mode,
  input  logic                  cfg_clr,
  output logic [2*NUM_CH-1:0]   sts_mode,
  output logic [NUM_CH-1:0]     sts_sat,
  output logic [31:0]           sts_pkt_cnt,
  output logic [31:0]           sts_smp_cnt
);
  localparam int W = NUM_CH * ITEM_W;

  logic                en;
  logic                acc;
  logic                sop;
  logic                beat_par;
  logic                m_xfer;
  logic [2*NUM_CH-1:0] beat_mode;

  logic                in_pkt_q;
  logic                parity_q;
  logic [2*NUM_CH-1:0] mode_q;

  logic                v1_q;
  logic [W-1:0]        d1_q;
  logic                l1_q;
  logic [2*NUM_CH-1:0] m1_q;
  logic                p1_q;

  logic                v2_q;
  logic [W-1:0]        d2_q;
  logic                l2_q;
  logic [NUM_CH-1:0]   s2_q;

  logic [W-1:0]        lane_res;
  logic [NUM_CH-1:0]   lane_sat;
  logic [NUM_CH-1:0]   sat_q;
  logic [NUM_CH-1:0]   sat_d;

  assign en            = m_axis.tready | ~v2_q;
  assign s_axis.tready = en;
  assign acc           = s_axis.tvalid & en;
  assign sop           = ~in_pkt_q;
  assign beat_mode     = sop ? cfg_mode : mode_q;
  assign beat_par      = (sop && (PARITY_PER_PKT != 0)) ? 1'b0 : parity_q;
  assign m_xfer        = v2_q & m_axis.tready;

  // Stage 1 capture plus packet tracking, parity and mode latching
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      in_pkt_q <= 1'b0;
      parity_q <= 1'b0;
      mode_q   <= '0;
      v1_q     <= 1'b0;
      d1_q     <= '0;
      l1_q     <= 1'b0;
      m1_q     <= '0;
      p1_q     <= 1'b0;
    end else if (en) begin
      v1_q <= acc;
      if (acc) begin
        d1_q     <= s_axis.tdata;
        l1_q     <= s_axis.tlast;
        m1_q     <= beat_mode;
        p1_q     <= beat_par;
        in_pkt_q <= ~s_axis.tlast;
        parity_q <= ~beat_par;
        if (sop) begin
          mode_q <= cfg_mode;
        end
      end
    end
  end

  // Per-channel arithmetic on the stage 1 beat
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    specinvert_lane #(
      .ITEM_W (ITEM_W)
    ) u_lane (
      .item_i   (d1_q[c*ITEM_W +: ITEM_W]),
      .mode_i   (specinv_mode_t'(m1_q[2*c +: 2])),
      .parity_i (p1_q),
      .item_o   (lane_res[c*ITEM_W +: ITEM_W]),
      .sat_o    (lane_sat[c])
    );
  end

  // Stage 2 holds the result; frozen while the output is stalled
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      v2_q <= 1'b0;
      d2_q <= '0;
      l2_q <= 1'b0;
      s2_q <= '0;
    end else if (en) begin
      v2_q <= v1_q;
      l2_q <= v1_q & l1_q;
      if (v1_q) begin
        d2_q <= lane_res;
        s2_q <= lane_sat;
      end
    end
  end

  // Saturation flags accumulate only on transferred beats; clear wins
  always_comb begin
    sat_d = sat_q;
    if (cfg_clr) begin
      sat_d = '0;
    end else if (m_xfer) begin
      sat_d = sat_q | s2_q;
    end
  end

  // Sticky saturation register
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign m_axis.tdata  = d2_q;
  assign m_axis.tlast  = l2_q;
  assign m_axis.tvalid = v2_q;
  assign sts_mode      = mode_q;
  assign sts_sat       = sat_q;

`ifdef SPECINV_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] smp_cnt_q;

  // Output beat and packet counters, wrapping; clear wins over increment
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      pkt_cnt_q <= 32'd0;
      smp_cnt_q <= 32'd0;
    end else if (cfg_clr) begin
      pkt_cnt_q <= 32'd0;
      smp_cnt_q <= 32'd0;
    end else if (m_xfer) begin
      smp_cnt_q <= smp_cnt_q + 32'd1;
      if (l2_q) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
    end
  end

  assign sts_pkt_cnt = pkt_cnt_q;
  assign sts_smp_cnt = smp_cnt_q;
`else
  assign sts_pkt_cnt = 32'd0;
  assign sts_smp_cnt = 32'd0;
`endif

endmodule
